seg_scan_driver: RTL and testbench

- Downstream consumer of the wall-clock timer: takes the 4-digit BCD time word and its decimal-point mask and time-multiplexes them onto a common-anode 4-digit 7-segment display.
- Frame-synchronous snapshot of the input prevents digit tearing mid-scan.
- Provides leading-zero blanking and an optional whole-display blink, used to flag the stopped state.

---
 rtl/seg_scan_driver.sv | 130 +++++++++++++
 tb/tb_seg_scan_driver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a common-anode 4-digit 7-segment display.
// Latches the BCD time word once per frame, blanks leading zeros and can blink the whole display.
module seg_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int BLANK_LZ     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Time_in,
    input  logic [3:0]  s_point,
    input  logic        blink_en,
    output logic [3:0]  AN,
    output logic [7:0]  SEGMENT
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic          run_q, run_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          phase_q, phase_d;
    logic [15:0]   time_snap_q, time_snap_d;
    logic [3:0]    sp_snap_q, sp_snap_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    logic          tick, wrap, blank, dp;
    logic [3:0]    nib;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        tick  = (pre_q == PRE_MAX);
        pre_d = tick ? '0 : pre_q + PW'(1);

        // The first tick after reset opens the digit-0 slot instead of advancing,
        // so scanning restarts at digit 0 one slot after release.
        run_d = run_q | tick;
        idx_d = idx_q;
        wrap  = 1'b0;
        if (tick && run_q) begin
            idx_d = idx_q + 2'd1;
            wrap  = (idx_q == 2'd3);
        end

        time_snap_d = wrap ? Time_in : time_snap_q;
        sp_snap_d   = wrap ? s_point : sp_snap_q;

        frm_d   = frm_q;
        phase_d = phase_q;
        if (!blink_en) begin
            frm_d   = '0;
            phase_d = 1'b1;
        end else if (wrap) begin
            if (frm_q == FRM_MAX) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FW'(1);
            end
        end

        nib   = 4'(time_snap_d >> {idx_d, 2'b00});
        dp    = sp_snap_d[idx_d];
        blank = 1'b0;
        if (BLANK_LZ != 0) begin
            case (idx_d)
                2'd3:    blank = (time_snap_d[15:12] == 4'd0) && !sp_snap_d[3];
                2'd2:    blank = (time_snap_d[15:8] == 8'd0) && !sp_snap_d[2];
                default: blank = 1'b0;
            endcase
        end

        // Outputs track the next-state index so they change on the same edge as the slot.
        an_d  = 4'b1111;
        seg_d = 8'hFF;
        if (run_d) begin
            seg_d = blank ? 8'hFF : {~dp, seg7(nib)};
            if (!(blink_en && !phase_d))
                an_d = ~(4'b0001 << idx_d);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q       <= '0;
            idx_q       <= 2'd0;
            run_q       <= 1'b0;
            frm_q       <= '0;
            phase_q     <= 1'b1;
            time_snap_q <= 16'd0;
            sp_snap_q   <= 4'd0;
            an_q        <= 4'b1111;
            seg_q       <= 8'hFF;
        end else begin
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            run_q       <= run_d;
            frm_q       <= frm_d;
            phase_q     <= phase_d;
            time_snap_q <= time_snap_d;
            sp_snap_q   <= sp_snap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign AN      = an_q;
    assign SEGMENT = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, BLINK_FRAMES=2.
// Edge numbering: E1 is the first rising clk edge after reset release; frame f digit d opens at E(16f+4d+4).
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] Time_in;
    logic [3:0]  s_point;
    logic        blink_en;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;

    int n_pass = 0;
    int n_tot  = 0;
    int edge_n = 0;

    seg_scan_driver #(.SCAN_DIV(4), .BLINK_FRAMES(2), .BLANK_LZ(1)) dut (
        .clk(clk), .reset(reset), .Time_in(Time_in), .s_point(s_point),
        .blink_en(blink_en), .AN(AN), .SEGMENT(SEGMENT)
    );

    always #5 clk = ~clk;

    task automatic goto(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    task automatic test_reset;
        int         at [5];
        logic [11:0] ex [5];
        Time_in  = 16'h1234;
        s_point  = 4'b0000;
        blink_en = 1'b0;
        reset    = 1'b1;
        #2 reset = 1'b0;
        #18;
        n_tot++;
        if ({AN, SEGMENT} !== 12'hFFF)
            $display("FAIL rst_hold: got AN=%b SEG=%h, expected AN=1111 SEG=ff", AN, SEGMENT);
        else n_pass++;
        #30 reset = 1'b1;
        edge_n = 0;
        // Zero snapshot for the first frame: digits 3 and 2 blank, 1 and 0 show "0".
        at = '{3, 4, 8, 12, 16};
        ex = '{12'hFFF, 12'hEC0, 12'hDC0, 12'hBFF, 12'h7FF};
        for (int i = 0; i < 5; i++) begin
            goto(at[i]);
            n_tot++;
            if ({AN, SEGMENT} !== ex[i])
                $display("FAIL rst_start[E%0d]: got AN=%b SEG=%h, expected AN=%b SEG=%h",
                         at[i], AN, SEGMENT, ex[i][11:8], ex[i][7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_scan;
        logic [11:0] ex [4];
        ex = '{12'hE99, 12'hDB0, 12'hBA4, 12'h7F9};
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 4; k += 3) begin
                goto(20 + 4*d + k);
                n_tot++;
                if ({AN, SEGMENT} !== ex[d])
                    $display("FAIL scan_1234[d%0d+%0d]: got AN=%b SEG=%h, expected AN=%b SEG=%h",
                             d, k, AN, SEGMENT, ex[d][11:8], ex[d][7:0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_blank_lz;
        logic [11:0] ex [4];
        Time_in = 16'h0005;
        ex = '{12'hE92, 12'hDC0, 12'hBFF, 12'h7FF};
        for (int d = 0; d < 4; d++) begin
            goto(36 + 4*d);
            n_tot++;
            if ({AN, SEGMENT} !== ex[d])
                $display("FAIL blank_lz[d%0d]: got AN=%b SEG=%h, expected AN=%b SEG=%h",
                         d, AN, SEGMENT, ex[d][11:8], ex[d][7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_dp_unblank;
        logic [11:0] ex [4];
        s_point = 4'b0100;
        ex = '{12'hE92, 12'hDC0, 12'hB40, 12'h7FF};
        for (int d = 0; d < 4; d++) begin
            goto(52 + 4*d);
            n_tot++;
            if ({AN, SEGMENT} !== ex[d])
                $display("FAIL dp_unblank[d%0d]: got AN=%b SEG=%h, expected AN=%b SEG=%h",
                         d, AN, SEGMENT, ex[d][11:8], ex[d][7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_snapshot;
        int          at [6];
        logic [11:0] ex [6];
        Time_in = 16'h1234;
        s_point = 4'b0000;
        at = '{68, 72, 76, 80, 84, 88};
        ex = '{12'hE99, 12'hDB0, 12'hBA4, 12'h7F9, 12'hE80, 12'hDF8};
        for (int i = 0; i < 6; i++) begin
            goto(at[i]);
            n_tot++;
            if ({AN, SEGMENT} !== ex[i])
                $display("FAIL snapshot[E%0d]: got AN=%b SEG=%h, expected AN=%b SEG=%h",
                         at[i], AN, SEGMENT, ex[i][11:8], ex[i][7:0]);
            else n_pass++;
            if (at[i] == 72) begin
                goto(73);
                Time_in = 16'h5678;
            end
        end
    endtask

    task automatic test_dash;
        logic [11:0] ex [4];
        goto(96);
        Time_in = 16'h00A9;
        ex = '{12'hE90, 12'hDBF, 12'hBFF, 12'h7FF};
        for (int d = 0; d < 4; d++) begin
            goto(100 + 4*d);
            n_tot++;
            if ({AN, SEGMENT} !== ex[d])
                $display("FAIL dash[d%0d]: got AN=%b SEG=%h, expected AN=%b SEG=%h",
                         d, AN, SEGMENT, ex[d][11:8], ex[d][7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_blink;
        int         at [11];
        logic [3:0] ex [11];
        goto(116);
        blink_en = 1'b1;
        at = '{120, 140, 147, 148, 160, 170, 180, 200, 212, 220, 230};
        ex = '{4'hD, 4'hB, 4'h7, 4'hF, 4'hF, 4'hF, 4'hE, 4'hD, 4'hF, 4'hF, 4'hF};
        for (int i = 0; i < 11; i++) begin
            goto(at[i]);
            n_tot++;
            if (AN !== ex[i])
                $display("FAIL blink[E%0d]: got AN=%b, expected AN=%b", at[i], AN, ex[i]);
            else n_pass++;
        end
        blink_en = 1'b0;
        goto(231);
        n_tot++;
        if (AN !== 4'b1110) $display("FAIL blink_drop: got AN=%b, expected AN=1110", AN);
        else n_pass++;
        goto(236);
        n_tot++;
        if (AN !== 4'b1011) $display("FAIL blink_resume: got AN=%b, expected AN=1011", AN);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int          at [5];
        logic [11:0] ex [5];
        #2 reset = 1'b0;
        #1;
        n_tot++;
        if ({AN, SEGMENT} !== 12'hFFF)
            $display("FAIL rst_async: got AN=%b SEG=%h, expected AN=1111 SEG=ff", AN, SEGMENT);
        else n_pass++;
        @(negedge clk);
        reset  = 1'b1;
        edge_n = 0;
        at = '{3, 4, 8, 12, 20};
        ex = '{12'hFFF, 12'hEC0, 12'hDC0, 12'hBFF, 12'hE90};
        for (int i = 0; i < 5; i++) begin
            goto(at[i]);
            n_tot++;
            if ({AN, SEGMENT} !== ex[i])
                $display("FAIL rst_mid[E%0d]: got AN=%b SEG=%h, expected AN=%b SEG=%h",
                         at[i], AN, SEGMENT, ex[i][11:8], ex[i][7:0]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_blank_lz;
        goto(48);
        test_dp_unblank;
        goto(64);
        test_snapshot;
        test_dash;
        test_blink;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
